// File: rtl/i2s_rx_if.sv
// I2S receive port bundle: serial pins towards the receiver and the
// parallel sample outputs coming back from it.
interface i2s_rx_if #(
    parameter int size = 16
);
    logic            sck;
    logic            ws;
    logic            sd;
    logic            valid;
    logic [size-1:0] out;
    logic            out_right;
    logic            frame_err;

    modport master (
        output sck, ws, sd,
        input  valid, out, out_right, frame_err
    );

    modport slave (
        input  sck, ws, sd,
        output valid, out, out_right, frame_err
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes sck/ws/sd into clk, frames words on ws changes
// and presents each sample (full or left-justified short) with a valid pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset; wait for the first ws change before framing words
// SHIFT | shifting bits of the current word, MSB first
// SKIP  | word complete; ignore extra slot bits until the next ws change
module i2s_rx #(
    parameter int size        = 16,
    parameter int sync_stages = 2
) (
    input  logic   clk,
    input  logic   rst,
    i2s_rx_if.slave bus
);
    localparam int cnt_w = $clog2(size + 1);
    localparam logic [cnt_w-1:0] cnt_full = cnt_w'(size);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SKIP  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [sync_stages-1:0] sck_sync;
    logic [sync_stages-1:0] ws_sync;
    logic [sync_stages-1:0] sd_sync;
    logic sck_s, ws_s, sd_s;

    logic sck_prev;
    logic rise_d;
    logic ws_d;
    logic sd_d;
    logic ws_prev;
    logic ws_change;

    logic [size-1:0]  shreg, shreg_next, shifted;
    logic [cnt_w-1:0] cnt, cnt_next, cnt_inc;
    logic [size-1:0]  out_q, out_next;
    logic             out_right_q, out_right_next;
    logic             valid_q, valid_next;
    logic             err_q, err_next;
    logic             word_ch, word_ch_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
        end else begin
            sck_sync <= {sck_sync[sync_stages-2:0], bus.sck};
            ws_sync  <= {ws_sync[sync_stages-2:0], bus.ws};
            sd_sync  <= {sd_sync[sync_stages-2:0], bus.sd};
        end
    end

    assign sck_s = sck_sync[sync_stages-1];
    assign ws_s  = ws_sync[sync_stages-1];
    assign sd_s  = sd_sync[sync_stages-1];

    // ws and sd are captured in the same cycle the sck rise is seen, so both
    // belong to the same bit even though they were synchronized separately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_prev <= 1'b0;
            rise_d   <= 1'b0;
            ws_d     <= 1'b0;
            sd_d     <= 1'b0;
        end else begin
            sck_prev <= sck_s;
            rise_d   <= sck_s & ~sck_prev;
            ws_d     <= ws_s;
            sd_d     <= sd_s;
        end
    end

    assign ws_change = rise_d & (ws_d != ws_prev);
    assign shifted   = {shreg[size-2:0], sd_d};
    assign cnt_inc   = (cnt == cnt_full) ? cnt : cnt + cnt_w'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ws_prev     <= 1'b0;
            shreg       <= '0;
            cnt         <= '0;
            out_q       <= '0;
            out_right_q <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            word_ch     <= 1'b0;
        end else begin
            state       <= state_next;
            if (rise_d)
                ws_prev <= ws_d;
            shreg       <= shreg_next;
            cnt         <= cnt_next;
            out_q       <= out_next;
            out_right_q <= out_right_next;
            valid_q     <= valid_next;
            err_q       <= err_next;
            word_ch     <= word_ch_next;
        end
    end

    // The bit sampled on a ws-change edge is the LSB of the outgoing word,
    // so it is shifted in before the word is closed.
    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        cnt_next       = cnt;
        out_next       = out_q;
        out_right_next = out_right_q;
        valid_next     = 1'b0;
        err_next       = err_q;
        word_ch_next   = word_ch;

        if (rise_d) begin
            case (state)
                IDLE: begin
                    if (ws_change) begin
                        state_next   = SHIFT;
                        cnt_next     = '0;
                        shreg_next   = '0;
                        word_ch_next = ws_d;
                    end
                end

                SHIFT: begin
                    if (ws_change && cnt == '0) begin
                        cnt_next     = '0;
                        shreg_next   = '0;
                        word_ch_next = ws_d;
                    end else begin
                        shreg_next = shifted;
                        cnt_next   = cnt_inc;
                        if (cnt_inc == cnt_full) begin
                            out_next       = shifted;
                            out_right_next = word_ch;
                            valid_next     = 1'b1;
                            state_next     = SKIP;
                        end else if (ws_change) begin
                            out_next       = shifted << (cnt_full - cnt_inc);
                            out_right_next = word_ch;
                            valid_next     = 1'b1;
                            err_next       = 1'b1;
                        end
                        if (ws_change) begin
                            state_next   = SHIFT;
                            cnt_next     = '0;
                            shreg_next   = '0;
                            word_ch_next = ws_d;
                        end
                    end
                end

                SKIP: begin
                    if (ws_change) begin
                        state_next   = SHIFT;
                        cnt_next     = '0;
                        shreg_next   = '0;
                        word_ch_next = ws_d;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.valid     = valid_q;
    assign bus.out       = out_q;
    assign bus.out_right = out_right_q;
    assign bus.frame_err = err_q;
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter: size, 16, sample width in bits (range 8..32).
REQ-002 Parameter: sync_stages, 2, synchronizer flops per external input (range 2..3).
REQ-003 clk  input  1  system clock; must be at least 4x sck frequency.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sck  input  1  I2S bit clock, asynchronous to clk.
REQ-006 ws  input  1  I2S word select: 0 = left, 1 = right; asynchronous to clk.
REQ-007 sd  input  1  I2S serial data, MSB first; asynchronous to clk.
REQ-008 valid  output  1  one-clk pulse marking a new sample on out.
REQ-009 out  output  size  last captured sample, two's complement; held between valid pulses.
REQ-010 out_right  output  1  channel of out: 1 = right, 0 = left; updated with out.
REQ-011 frame_err  output  1  sticky flag: a short word was received; cleared only by rst.

Function
REQ-012 sck, ws and sd each SHALL pass through a sync_stages-deep flop chain clocked by clk before any use.
REQ-013 Sampling SHALL occur on a synchronized sck rising edge, detected as 0 in the previous synchronized sample and 1 in the current one.
REQ-014 On each sck rising edge, ws and sd SHALL be sampled from the same synchronized clk cycle.
REQ-015 A ws change SHALL be detected when the ws value sampled at the current sck rising edge differs from the value sampled at the previous sck rising edge.
REQ-016 Per I2S, the sck rising edge that follows a detected ws change SHALL carry the MSB of the new word; its channel is the new ws value.
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and SKIP.
REQ-018 IDLE: entered on reset; the partial word in flight is discarded; on a detected ws change go to SHIFT with the bit counter at 0.
REQ-019 SHIFT: on each sck rising edge, shift sd into the LSB of the shift register and increment the bit counter.
REQ-020 SHIFT: when the counter reaches size, latch the word to out, set out_right to the word's channel, pulse valid, and go to SKIP.
REQ-021 SKIP: ignore sd bits beyond size; on a detected ws change go to SHIFT with the counter cleared.
REQ-022 Short word (ws change in SHIFT with counter at k, 0 < k < size): left-justify the k bits, zero the size-k LSBs, latch and pulse valid, set frame_err, then start the new word.
REQ-023 A ws change in SHIFT with counter at 0 SHALL emit nothing and restart the word.
REQ-024 The valid pulse SHALL be asserted in the clk cycle after the triggering sck edge is detected; total latency from the pin edge is sync_stages+2 clk cycles.
REQ-025 valid SHALL never be high for two consecutive clk cycles.
REQ-026 The bit counter SHALL be $clog2(size+1) bits wide and SHALL saturate; it never wraps.
REQ-027 out and out_right SHALL change only in the cycle valid is high.

Reset
REQ-028 When rst is high: out = 0, out_right = 0, valid = 0, frame_err = 0, state = IDLE, counter = 0, shift register = 0, synchronizers = 0.
REQ-029 Asserting rst mid-word SHALL abort the word with no valid pulse.
REQ-030 After reset release, the first valid SHALL come only after a complete word that follows a ws change.
REQ-031 The previous ws history SHALL reset to 0, so the first rising edge sampled with ws = 1 counts as a ws change.

Verification
REQ-032 size=16, clk = 8x sck, left 0x8001 then right 0x7FFE -> two valid pulses: out=0x8001 with out_right=0, then out=0x7FFE with out_right=1; frame_err=0.
REQ-033 size=16, 24-bit slots, left word 0xABCD12 -> out=0xABCD; trailing bits ignored; next word aligned correctly.
REQ-034 size=16, left slot of 12 bits 0xFFF -> out=0xFFF0, valid pulses at the ws change, frame_err=1 and stays 1.
REQ-035 rst asserted after bit 7 of a word, released, stream resumes -> no valid for the aborted word or the first partial word; next full word correct.
REQ-036 Stream starts mid-frame with ws=0 -> first valid only after the next full word; valid spacing is at least 1 clk and never back-to-back.
REQ-037 Random data, clk/sck ratio swept 4..16 with random phase -> every out equals the reference model; latency equals sync_stages+2.
